uart_rx: RTL and testbench

UART receiver for 8N1 serial frames: 8 data bits, LSB first, no parity, one stop bit. It is the receive-side counterpart of the SoC UART transmitter and sits in the UART peripheral between the asynchronous RX pin and the register or FIFO logic. The line is synchronized, the start bit is validated at mid-bit, each data bit and the stop bit are sampled at bit centre, and received bytes are presented on a valid/ready holding register. Framing-error and overrun events are reported as single-cycle pulses.

---
 rtl/uart_rx.sv | 151 +++++++++++++++
 tb/tb_uart_rx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit start validation, bit-centre
// sampling, and a valid/ready holding register with framing/overrun pulses.
//
// state     | meaning
// IDLE      | line idle, waiting for a low level on rx_s
// START     | timing half a bit to re-check the start bit
// DATA      | sampling 8 data bits at bit centre, LSB first
// STOP      | sampling the stop bit at bit centre
// WAIT_HIGH | stop bit was low; waiting for the line to return high
module uart_rx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_WIDTH    = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_WIDTH-1:0] HALF_LAST = CNT_WIDTH'(HALF_BIT - 1);
    localparam logic [CNT_WIDTH-1:0] BIT_LAST  = CNT_WIDTH'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_cfg
            $error("uart_rx: CLK_FREQ/BAUD must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           sync_q;
    logic                 rx_s;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [7:0]           shift_q, shift_d;
    logic                 complete;
    logic                 frame_err_d;

    assign rx_s   = sync_q[1];
    assign busy_o = (state_q != IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q    <= 2'b11;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            sync_q    <= {sync_q[0], rx_i};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_WIDTH'(1);
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        complete    = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // A completing byte may replace the held one only if it is consumed in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= frame_err_d;
            overrun_o   <= 1'b0;
            if (complete) begin
                if (!valid_o || ready_i) begin
                    data_o  <= shift_q;
                    valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit: frames, glitch, framing
// error, overrun, and mid-frame reset.
module tb_uart_rx;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int CPB      = 10;

    logic       clk_i   = 1'b0;
    logic       rst_ni  = 1'b0;
    logic       rx_i    = 1'b1;
    logic       ready_i = 1'b0;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    always #5 clk_i = ~clk_i;

    uart_rx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rx_i       (rx_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o),
        .busy_o     (busy_o)
    );

    int total = 0;
    int bad   = 0;

    // Event log: transfers, and cycle/rise counts of the pulse outputs.
    logic [7:0] xfer_mem [0:63];
    int   xfer_n    = 0;
    int   ferr_cyc  = 0;
    int   ferr_rise = 0;
    int   ovr_cyc   = 0;
    int   ovr_rise  = 0;
    logic ferr_prev = 1'b0;
    logic ovr_prev  = 1'b0;

    always @(negedge clk_i) begin
        if (valid_o && ready_i) begin
            xfer_mem[xfer_n[5:0]] <= data_o;
            xfer_n <= xfer_n + 1;
        end
        if (frame_err_o) ferr_cyc <= ferr_cyc + 1;
        if (frame_err_o && !ferr_prev) ferr_rise <= ferr_rise + 1;
        if (overrun_o) ovr_cyc <= ovr_cyc + 1;
        if (overrun_o && !ovr_prev) ovr_rise <= ovr_rise + 1;
        ferr_prev <= frame_err_o;
        ovr_prev  <= overrun_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic send_head(input logic [7:0] b);
        rx_i = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            tick(CPB);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_len);
        send_head(b);
        rx_i = stop_bit;
        tick(stop_len);
        rx_i = 1'b1;
    endtask

    initial begin
        int xb;
        int fb;
        int fr;
        int ob;
        int orb;
        logic [7:0] c3;

        // reset state
        tick(3);
        check("rst_data", 32'(data_o), 32'h0);
        check("rst_valid", 32'(valid_o), 32'h0);
        check("rst_ferr", 32'(frame_err_o), 32'h0);
        check("rst_ovr", 32'(overrun_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        rst_ni = 1'b1;
        tick(5);

        // single byte
        ready_i = 1'b1;
        xb = xfer_n; fb = ferr_cyc; ob = ovr_cyc;
        send_frame(8'hA5, 1'b1, CPB);
        tick(5);
        check("t1_count", 32'(xfer_n - xb), 32'd1);
        check("t1_data", 32'(xfer_mem[xb]), 32'hA5);
        check("t1_ferr", 32'(ferr_cyc - fb), 32'd0);
        check("t1_ovr", 32'(ovr_cyc - ob), 32'd0);
        check("t1_valid_low", 32'(valid_o), 32'h0);

        // back-to-back
        xb = xfer_n;
        send_frame(8'h00, 1'b1, CPB);
        send_frame(8'hFF, 1'b1, CPB);
        send_frame(8'h3C, 1'b1, CPB);
        tick(5);
        check("t2_count", 32'(xfer_n - xb), 32'd3);
        check("t2_b0", 32'(xfer_mem[xb]), 32'h00);
        check("t2_b1", 32'(xfer_mem[xb+1]), 32'hFF);
        check("t2_b2", 32'(xfer_mem[xb+2]), 32'h3C);

        // glitch rejection
        xb = xfer_n; fb = ferr_cyc;
        rx_i = 1'b0;
        tick(3);
        rx_i = 1'b1;
        tick(2);
        check("t3_busy_start", 32'(busy_o), 32'h1);
        tick(10);
        check("t3_busy_idle", 32'(busy_o), 32'h0);
        check("t3_count", 32'(xfer_n - xb), 32'd0);
        check("t3_ferr", 32'(ferr_cyc - fb), 32'd0);

        // framing error with line held low, then recovery
        xb = xfer_n; fb = ferr_cyc; fr = ferr_rise;
        send_head(8'h55);
        rx_i = 1'b0;
        tick(20);
        check("t4_busy_wait", 32'(busy_o), 32'h1);
        check("t4_ferr_seen", 32'(ferr_rise - fr), 32'd1);
        tick(20);
        rx_i = 1'b1;
        tick(120);
        check("t4_ferr_rise", 32'(ferr_rise - fr), 32'd1);
        check("t4_ferr_cyc", 32'(ferr_cyc - fb), 32'd1);
        check("t4_no_byte", 32'(xfer_n - xb), 32'd0);
        check("t4_busy_idle", 32'(busy_o), 32'h0);
        send_frame(8'h12, 1'b1, CPB);
        tick(5);
        check("t4_count", 32'(xfer_n - xb), 32'd1);
        check("t4_data", 32'(xfer_mem[xb]), 32'h12);
        check("t4_data_o", 32'(data_o), 32'h12);

        // overrun with consumer stalled
        ready_i = 1'b0;
        xb = xfer_n; ob = ovr_cyc; orb = ovr_rise;
        send_frame(8'h11, 1'b1, CPB);
        send_frame(8'h22, 1'b1, CPB);
        tick(5);
        check("t5_ovr_rise", 32'(ovr_rise - orb), 32'd1);
        check("t5_ovr_cyc", 32'(ovr_cyc - ob), 32'd1);
        check("t5_valid", 32'(valid_o), 32'h1);
        check("t5_data_kept", 32'(data_o), 32'h11);
        check("t5_no_xfer", 32'(xfer_n - xb), 32'd0);
        ready_i = 1'b1;
        tick(1);
        ready_i = 1'b0;
        tick(1);
        check("t5_valid_drop", 32'(valid_o), 32'h0);
        check("t5_xfer_count", 32'(xfer_n - xb), 32'd1);
        check("t5_xfer_data", 32'(xfer_mem[xb]), 32'h11);

        // ready asserted exactly in the completion cycle: replace, no overrun
        xb = xfer_n; orb = ovr_rise;
        send_frame(8'h11, 1'b1, CPB);
        tick(5);
        send_head(8'h22);
        rx_i = 1'b1;
        tick(7);
        ready_i = 1'b1;
        tick(1);
        ready_i = 1'b0;
        tick(2);
        check("t5b_no_ovr", 32'(ovr_rise - orb), 32'd0);
        check("t5b_valid", 32'(valid_o), 32'h1);
        check("t5b_data", 32'(data_o), 32'h22);
        check("t5b_xfer_count", 32'(xfer_n - xb), 32'd1);
        check("t5b_xfer_data", 32'(xfer_mem[xb]), 32'h11);
        ready_i = 1'b1;
        tick(2);
        check("t5b_drain", 32'(xfer_mem[xb+1]), 32'h22);
        check("t5b_valid_drop", 32'(valid_o), 32'h0);

        // reset during data bit 4
        xb = xfer_n;
        c3 = 8'hC3;
        rx_i = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx_i = c3[i];
            tick(CPB);
        end
        rx_i = c3[4];
        tick(5);
        check("t6_busy_pre", 32'(busy_o), 32'h1);
        rst_ni = 1'b0;
        #1;
        check("t6_data", 32'(data_o), 32'h0);
        check("t6_valid", 32'(valid_o), 32'h0);
        check("t6_busy", 32'(busy_o), 32'h0);
        check("t6_ferr", 32'(frame_err_o), 32'h0);
        check("t6_ovr", 32'(overrun_o), 32'h0);
        rx_i = 1'b1;
        tick(3);
        rst_ni = 1'b1;
        tick(20);
        check("t6_no_stale", 32'(xfer_n - xb), 32'd0);
        send_frame(8'h7E, 1'b1, CPB);
        tick(5);
        check("t6_count", 32'(xfer_n - xb), 32'd1);
        check("t6_xfer", 32'(xfer_mem[xb]), 32'h7E);
        check("t6_data_o", 32'(data_o), 32'h7E);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
